// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - data-memory responder for the load/store port
// Single outstanding request with fixed latency; byte-lane stores and sign/zero-extended loads.
module data_mem_resp #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam int CW    = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  enter_resp;
  logic                  cur_write;
  logic [2:0]            cur_funct3;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [DATA_WIDTH-1:0] load_data;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlane;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign accept       = req_valid_i & req_ready_o;

  // With LATENCY=1 the response is produced on the accept edge, so use live inputs in IDLE.
  always_comb begin
    cur_write  = write_q;
    cur_funct3 = funct3_q;
    cur_addr   = addr_q;
    cur_wdata  = wdata_q;
    if (state_q == S_IDLE) begin
      cur_write  = req_write_i;
      cur_funct3 = req_funct3_i;
      cur_addr   = req_addr_i;
      cur_wdata  = req_wdata_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_err = 1'b0;
    case (cur_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = cur_addr[0];
      3'b010:  req_err = |cur_addr[1:0];
      3'b100:  req_err = cur_write;
      3'b101:  req_err = cur_write | cur_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  assign rword = mem[cur_addr[ADDR_WIDTH-1:2]];

  always_comb begin
    rbyte = rword[7:0];
    case (cur_addr[1:0])
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = cur_addr[1] ? rword[31:16] : rword[15:0];
    load_data = '0;
    case (cur_funct3)
      3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b010:  load_data = rword;
      3'b100:  load_data = {24'b0, rbyte};
      3'b101:  load_data = {16'b0, rhalf};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wlane = cur_wdata;
    case (cur_funct3)
      3'b000: begin
        be    = 4'b0001 << cur_addr[1:0];
        wlane = {4{cur_wdata[7:0]}};
      end
      3'b001: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur_wdata[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign mem_we = enter_resp & cur_write & ~req_err & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[cur_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= req_write_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
      end
      if (enter_resp) begin
        rdata_q <= (req_err | cur_write) ? '0 : load_data;
        err_q   <= req_err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - directed self-checking bench for data_mem_resp
// Two instances: LATENCY=2 (sel=0) and LATENCY=1 (sel=1) sharing clock and reset.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [16:0] addr = '0;
  logic [31:0] wdata = '0;

  logic        ready0, ready1, rv0, rv1, err0, err1, busy0, busy1;
  logic [31:0] rdata0, rdata1;
  logic        ready, rv, err, busy;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.ADDR_WIDTH(17), .DATA_WIDTH(32), .LATENCY(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & ~sel), .req_ready_o(ready0),
    .req_write_i(req_write), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata),
    .resp_valid_o(rv0), .resp_rdata_o(rdata0), .resp_err_o(err0), .busy_o(busy0)
  );

  data_mem_resp #(.ADDR_WIDTH(17), .DATA_WIDTH(32), .LATENCY(1)) u_dut_lat1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & sel), .req_ready_o(ready1),
    .req_write_i(req_write), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata),
    .resp_valid_o(rv1), .resp_rdata_o(rdata1), .resp_err_o(err1), .busy_o(busy1)
  );

  assign ready = sel ? ready1 : ready0;
  assign rv    = sel ? rv1    : rv0;
  assign err   = sel ? err1   : err0;
  assign busy  = sel ? busy1  : busy0;
  assign rdata = sel ? rdata1 : rdata0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues one request and checks latency, data, error and strobe width.
  task automatic access(input string tag, input logic w, input logic [2:0] fn,
                        input logic [16:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int n;
    req_write = w;
    f3        = fn;
    addr      = a;
    wdata     = d;
    req_valid = 1'b1;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      req_valid = 1'b0;
      check({tag, "/accept_timeout"}, 32'(ready), 32'd1);
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rv && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'(exp_lat));
    check({tag, "/rdata"}, rdata, exp_rdata);
    check({tag, "/err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    check({tag, "/strobe"}, 32'(rv), 32'd0);
  endtask

  initial begin
    int acc_cnt, resp_cnt, busy_bad;

    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst/resp_valid", 32'(rv), 32'd0);
    check("rst/rdata", rdata, 32'd0);
    check("rst/err", 32'(err), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst/ready", 32'(ready), 32'd1);

    access("sw_10",   1'b1, 3'b010, 17'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    access("lw_10",   1'b0, 3'b010, 17'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2);

    access("sb_13",   1'b1, 3'b000, 17'h13, 32'h00000080, 32'h0,        1'b0, 2);
    access("lb_13",   1'b0, 3'b000, 17'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2);
    access("lbu_13",  1'b0, 3'b100, 17'h13, 32'h0,        32'h00000080, 1'b0, 2);
    access("lw_10b",  1'b0, 3'b010, 17'h10, 32'h0,        32'h80ADBEEF, 1'b0, 2);

    access("sh_12",   1'b1, 3'b001, 17'h12, 32'h00001234, 32'h0,        1'b0, 2);
    access("lh_12",   1'b0, 3'b001, 17'h12, 32'h0,        32'h00001234, 1'b0, 2);
    access("lh_11",   1'b0, 3'b001, 17'h11, 32'h0,        32'h0,        1'b1, 2);
    access("sw_mis",  1'b1, 3'b010, 17'h12, 32'hFFFFFFFF, 32'h0,        1'b1, 2);
    access("lw_10c",  1'b0, 3'b010, 17'h10, 32'h0,        32'h1234BEEF, 1'b0, 2);
    access("f3_011",  1'b0, 3'b011, 17'h10, 32'h0,        32'h0,        1'b1, 2);
    access("sh_14",   1'b1, 3'b001, 17'h14, 32'h00009ABC, 32'h0,        1'b0, 2);
    access("lh_14",   1'b0, 3'b001, 17'h14, 32'h0,        32'hFFFF9ABC, 1'b0, 2);
    access("lhu_14",  1'b0, 3'b101, 17'h14, 32'h0,        32'h00009ABC, 1'b0, 2);

    req_write = 1'b0;
    f3        = 3'b010;
    addr      = 17'h10;
    req_valid = 1'b1;
    acc_cnt  = 0;
    resp_cnt = 0;
    busy_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (ready) acc_cnt++;
      if (rv) resp_cnt++;
      if (busy == ready) busy_bad++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("hold/accepts", 32'(acc_cnt), 32'd4);
    check("hold/responses", 32'(resp_cnt), 32'd4);
    check("hold/busy_vs_ready", 32'(busy_bad), 32'd0);
    @(negedge clk);

    access("sw_20",   1'b1, 3'b010, 17'h20, 32'h11111111, 32'h0,        1'b0, 2);
    access("lw_10d",  1'b0, 3'b010, 17'h10, 32'h0,        32'h1234BEEF, 1'b0, 2);
    req_write = 1'b1;
    f3        = 3'b010;
    addr      = 17'h20;
    wdata     = 32'h00000005;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid/busy", 32'(busy), 32'd0);
    check("rstmid/rdata", rdata, 32'd0);
    check("rstmid/err", 32'(err), 32'd0);
    #2 rst = 1'b0;
    resp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rv) resp_cnt++;
    end
    check("rstmid/no_resp", 32'(resp_cnt), 32'd0);
    access("lw_20",   1'b0, 3'b010, 17'h20, 32'h0,        32'h11111111, 1'b0, 2);

    sel = 1'b1;
    access("l1_sw_40", 1'b1, 3'b010, 17'h40, 32'hCAFEF00D, 32'h0,        1'b0, 1);
    access("l1_lw_40", 1'b0, 3'b010, 17'h40, 32'h0,        32'hCAFEF00D, 1'b0, 1);
    access("l1_lb_43", 1'b0, 3'b000, 17'h43, 32'h0,        32'hFFFFFFCA, 1'b0, 1);
    access("l1_lw_mis", 1'b0, 3'b010, 17'h41, 32'h0,       32'h0,        1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
